middle_nonlinear_pipe: RTL
==========================

Name: middle_nonlinear_pipe

Overview:
Pipelined nonlinear middle section of the depth-16 forward AES S-box. It takes the byte U and the top-linear outputs T1-T27, and produces the 63 products/sums M1-M63 as M[62:0] (paper index minus one). M[62:0] feeds bottom_linear_forward directly. The block has a valid/ready handshake, carries a side-band tag alongside each datum, and stalls without losing or duplicating data.

Parameters:
TAG_W, 4, width of the side-band tag carried with each datum; legal range 1..16.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  U/T/in_tag are valid this cycle
in_ready  output  1  the block accepts a datum this cycle
U  input  8  S-box input byte, U[7]=U0 (paper order, MSB first)
T  input  27  top-linear outputs, T[k]=T(k+1)
in_tag  input  TAG_W  opaque tag
out_valid  output  1  M/out_tag are valid
out_ready  input  1  downstream accepts this cycle
M  output  63  M[k]=M(k+1) of the depth-16 circuit
out_tag  output  TAG_W  tag of the datum on M

Behaviour:
- A transfer occurs on a cycle where valid&&ready at a port; the sampling edge is rising clk.
- Stage 0 (input regs): captures U, T and tag on an accepted input.
- Stage 1: computes M1-M45 combinationally from the stage-0 regs, where M41-M45 are the GF(2^4) inversion outputs. It registers M[44:0] and forwards U, T and tag.
- Stage 2: computes M46-M63 (the 18 ANDs of M41-M45 with T/U terms) from the stage-1 regs. It registers the full M[62:0] and the tag into the output regs.
- Equations are exactly those of the Boyar-Peralta depth-16 circuit, with the index shifted by one.
- Latency: 3 cycles from an accepted input to out_valid, with no stalls. Throughput is 1 per cycle.
- Each stage has its own valid bit v0/v1/v2, and out_valid=v2.
- A stage advances when the next stage is empty or advancing. The output stage advances when out_ready=1.
- in_ready = !v0 || stage-0 advancing. This is combinational from out_ready through the chain, with no skid buffer.
- Bubbles collapse: an empty stage accepts new data even while a later stage stalls.
- While stalled (out_valid=1, out_ready=0), M and out_tag hold stable, and no stage overwrites an occupied stage that cannot advance.
- If in_valid=1 while in_ready=0, the input is not consumed, and the upstream holds it.
- Back-to-back transfers with out_ready=1 continuously yield one output per cycle, in order.
- Reset: v0=v1=v2=0, so out_valid=0 and in_ready=1 in the cycle after rst. M and out_tag reset to 0.
- Data regs reset too, so outputs are deterministic.
- Reset mid-operation discards all in-flight data; no partial output appears after reset.
- rst takes priority over any simultaneous transfer.
- X/unknown on U/T while in_valid=0 must not propagate to out_valid.

Test Plan:
Chain with top_linear_forward and bottom_linear_forward in the bench, with out_ready=1:
- U=0x00 -> S=0x63, out_valid exactly 3 cycles after accept.
- U=0x53 -> S=0xED.
- U=0xFF -> S=0x16.
- U=0x01 -> S=0x7C.

Exhaustive streaming: all 256 bytes back-to-back with tag=U[3:0] -> 256 outputs in order, each S matches the AES S-box table, the tag matches, and there are no gaps after the first 3-cycle fill.

Backpressure: stream 0x00..0x0F with out_ready toggling in the pattern 1,0,0,1,... ->
- no loss or duplication;
- M and out_tag stable during every cycle with out_valid=1 and out_ready=0;
- in_ready=0 only when all 3 stages are full and out_ready=0.

Bubble collapse: accept one datum, hold out_ready=0 for 5 cycles, and keep in_valid=1 -> exactly 3 data accepted, then in_ready=0 until out_ready=1.

Reset mid-flight: assert rst for 1 cycle with 3 data in flight -> out_valid=0 the next cycle, and the next accepted U=0x53 yields S=0xED after 3 cycles with no stale output before it.

Source files
------------

// File: rtl/middle_nonlinear_pipe.sv
// Three-stage valid/ready pipeline for the nonlinear middle of the depth-16 AES S-box.
// Stage 1 forms M1-M45 (GF(2^4) inversion), stage 2 forms the M46-M63 ANDs into the output regs.
module middle_nonlinear_pipe #(
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       U,
   input  logic [26:0]      T,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [62:0]      M,
   output logic [TAG_W-1:0] out_tag
);

   logic             v0_q, v1_q, v2_q;
   logic             v0_d, v1_d, v2_d;
   logic [7:0]       u0_q, u1_q;
   logic [27:1]      t0_q, t1_q;
   logic [TAG_W-1:0] tag0_q, tag1_q, tag2_q;
   logic [45:1]      m1_q, m1_d;
   logic [63:1]      m2_q, m2_d;

   logic ready1, ready2, accept, adv0, adv1;

   // Stage enables: a stage may load when it is empty or its contents move on this cycle.
   always_comb begin
      ready2 = !v2_q || out_ready;
      adv1   = v1_q && ready2;
      ready1 = !v1_q || ready2;
      adv0   = v0_q && ready1;
      in_ready = !v0_q || ready1;
      accept = in_valid && in_ready;
      v0_d   = accept || (v0_q && !ready1);
      v1_d   = adv0   || (v1_q && !ready2);
      v2_d   = adv1   || (v2_q && !out_ready);
   end

   // M1-M45 from the stage-0 registers; T(k) is t0_q[k], U7 is u0_q[0].
   always_comb begin
      m1_d     = '0;
      m1_d[1]  = t0_q[13] & t0_q[6];
      m1_d[2]  = t0_q[23] & t0_q[8];
      m1_d[3]  = t0_q[14] ^ m1_d[1];
      m1_d[4]  = t0_q[19] & u0_q[0];
      m1_d[5]  = m1_d[4] ^ m1_d[1];
      m1_d[6]  = t0_q[3] & t0_q[16];
      m1_d[7]  = t0_q[22] & t0_q[9];
      m1_d[8]  = t0_q[26] ^ m1_d[6];
      m1_d[9]  = t0_q[20] & t0_q[17];
      m1_d[10] = m1_d[9] ^ m1_d[6];
      m1_d[11] = t0_q[1] & t0_q[15];
      m1_d[12] = t0_q[4] & t0_q[27];
      m1_d[13] = m1_d[12] ^ m1_d[11];
      m1_d[14] = t0_q[2] & t0_q[10];
      m1_d[15] = m1_d[14] ^ m1_d[11];
      m1_d[16] = m1_d[3] ^ m1_d[2];
      m1_d[17] = m1_d[5] ^ t0_q[24];
      m1_d[18] = m1_d[8] ^ m1_d[7];
      m1_d[19] = m1_d[10] ^ m1_d[15];
      m1_d[20] = m1_d[16] ^ m1_d[13];
      m1_d[21] = m1_d[17] ^ m1_d[15];
      m1_d[22] = m1_d[18] ^ m1_d[13];
      m1_d[23] = m1_d[19] ^ t0_q[25];
      m1_d[24] = m1_d[22] ^ m1_d[23];
      m1_d[25] = m1_d[22] & m1_d[20];
      m1_d[26] = m1_d[21] ^ m1_d[25];
      m1_d[27] = m1_d[20] ^ m1_d[21];
      m1_d[28] = m1_d[23] ^ m1_d[25];
      m1_d[29] = m1_d[28] & m1_d[27];
      m1_d[30] = m1_d[26] & m1_d[24];
      m1_d[31] = m1_d[20] & m1_d[23];
      m1_d[32] = m1_d[27] & m1_d[31];
      m1_d[33] = m1_d[27] ^ m1_d[25];
      m1_d[34] = m1_d[21] & m1_d[22];
      m1_d[35] = m1_d[24] & m1_d[34];
      m1_d[36] = m1_d[24] ^ m1_d[25];
      m1_d[37] = m1_d[21] ^ m1_d[29];
      m1_d[38] = m1_d[32] ^ m1_d[33];
      m1_d[39] = m1_d[23] ^ m1_d[30];
      m1_d[40] = m1_d[35] ^ m1_d[36];
      m1_d[41] = m1_d[38] ^ m1_d[40];
      m1_d[42] = m1_d[37] ^ m1_d[39];
      m1_d[43] = m1_d[37] ^ m1_d[38];
      m1_d[44] = m1_d[39] ^ m1_d[40];
      m1_d[45] = m1_d[42] ^ m1_d[41];
   end

   // M46-M63: inversion outputs ANDed with the forwarded linear terms.
   always_comb begin
      m2_d       = '0;
      m2_d[45:1] = m1_q;
      m2_d[46]   = m1_q[44] & t1_q[6];
      m2_d[47]   = m1_q[40] & t1_q[8];
      m2_d[48]   = m1_q[39] & u1_q[0];
      m2_d[49]   = m1_q[43] & t1_q[16];
      m2_d[50]   = m1_q[38] & t1_q[9];
      m2_d[51]   = m1_q[37] & t1_q[17];
      m2_d[52]   = m1_q[42] & t1_q[15];
      m2_d[53]   = m1_q[45] & t1_q[27];
      m2_d[54]   = m1_q[41] & t1_q[10];
      m2_d[55]   = m1_q[44] & t1_q[13];
      m2_d[56]   = m1_q[40] & t1_q[23];
      m2_d[57]   = m1_q[39] & t1_q[19];
      m2_d[58]   = m1_q[43] & t1_q[3];
      m2_d[59]   = m1_q[38] & t1_q[22];
      m2_d[60]   = m1_q[37] & t1_q[20];
      m2_d[61]   = m1_q[42] & t1_q[1];
      m2_d[62]   = m1_q[45] & t1_q[4];
      m2_d[63]   = m1_q[41] & t1_q[2];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v0_q   <= 1'b0;
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         u0_q   <= '0;
         u1_q   <= '0;
         t0_q   <= '0;
         t1_q   <= '0;
         tag0_q <= '0;
         tag1_q <= '0;
         tag2_q <= '0;
         m1_q   <= '0;
         m2_q   <= '0;
      end else begin
         v0_q <= v0_d;
         v1_q <= v1_d;
         v2_q <= v2_d;
         if (accept) begin
            u0_q   <= U;
            t0_q   <= T;
            tag0_q <= in_tag;
         end
         if (adv0) begin
            u1_q   <= u0_q;
            t1_q   <= t0_q;
            tag1_q <= tag0_q;
            m1_q   <= m1_d;
         end
         if (adv1) begin
            m2_q   <= m2_d;
            tag2_q <= tag1_q;
         end
      end
   end

   assign out_valid = v2_q;
   assign M         = m2_q;
   assign out_tag   = tag2_q;

   // Only U7 and a subset of T reach the final ANDs; the rest rides along unused.
   logic unused_fwd;
   assign unused_fwd = ^{u1_q[7:1], t1_q};

endmodule
